// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: per-frame ball motion, wall bounces, paddle hits, scoring and winner.
// Optional macro SPEEDUP_EN: ball speed steps up on each paddle hit, capped at MAX_SPEED.
module pong_game_ctrl #(
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned MAX_SPEED    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       VS,
  input  logic       serve,
  input  logic [8:0] count_0,
  input  logic [8:0] count_1,
  input  logic [5:0] paddlewidth,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [1:0] winner,
  output logic [1:0] state
);
  localparam int unsigned CW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
  localparam logic [9:0] CX = 10'd316;
  localparam logic [8:0] CY = 9'd236;
  localparam logic signed [10:0] TOP = 11'sd11;
  localparam logic signed [10:0] BOT = 11'sd461;

  if (BALL_SPEED < 1 || BALL_SPEED > 7 || WIN_SCORE < 1 || WIN_SCORE > 9 ||
      PAUSE_FRAMES < 1 || MAX_SPEED > 7) begin : g_bad_params
    $error("pong_game_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_POINT = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t        state_q, state_nxt;
  logic          vs_d, tick;
  logic          dx, dy, dx_nxt, dy_nxt;
  logic [9:0]    bx_nxt;
  logic [8:0]    by_nxt;
  logic [3:0]    s0_nxt, s1_nxt;
  logic [1:0]    win_nxt;
  logic [CW-1:0] pause_cnt, cnt_nxt;
  logic [2:0]    speed;
  logic          hit, miss;
  logic signed [10:0] bx, by, sp, c0, c1, pw, ny;
  logic          ov0, ov1;

  assign tick  = vs_d & ~VS;
  assign state = state_q;
  assign bx    = $signed({1'b0, ball_x});
  assign by    = $signed({2'b00, ball_y});
  assign sp    = $signed({8'd0, speed});
  assign c0    = $signed({2'b00, count_0});
  assign c1    = $signed({2'b00, count_1});
  assign pw    = $signed({5'd0, paddlewidth});
  // Vertical overlap of the 9-pixel ball with each paddle, using the pre-move ball_y
  assign ov0   = (by + 11'sd8 >= c0) && (by <= c0 + pw);
  assign ov1   = (by + 11'sd8 >= c1) && (by <= c1 + pw);

`ifdef SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (rst || miss)                        speed <= 3'(BALL_SPEED);
    else if (hit && speed < 3'(MAX_SPEED))  speed <= speed + 3'd1;
  end
`else
  assign speed = 3'(BALL_SPEED);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vs_d      <= 1'b1;
      ball_x    <= CX;
      ball_y    <= CY;
      dx        <= 1'b1;
      dy        <= 1'b1;
      score0    <= 4'd0;
      score1    <= 4'd0;
      winner    <= 2'b00;
      pause_cnt <= '0;
    end else begin
      state_q   <= state_nxt;
      vs_d      <= VS;
      ball_x    <= bx_nxt;
      ball_y    <= by_nxt;
      dx        <= dx_nxt;
      dy        <= dy_nxt;
      score0    <= s0_nxt;
      score1    <= s1_nxt;
      winner    <= win_nxt;
      pause_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    bx_nxt    = ball_x;
    by_nxt    = ball_y;
    dx_nxt    = dx;
    dy_nxt    = dy;
    s0_nxt    = score0;
    s1_nxt    = score1;
    win_nxt   = winner;
    cnt_nxt   = pause_cnt;
    ny        = by;
    hit       = 1'b0;
    miss      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bx_nxt = CX;
        by_nxt = CY;
        if (serve) state_nxt = S_PLAY;
      end
      S_PLAY: if (tick) begin
        if (dy) begin
          ny = by + sp;
          if (ny > BOT) begin ny = BOT; dy_nxt = 1'b0; end
        end else begin
          ny = by - sp;
          if (ny < TOP) begin ny = TOP; dy_nxt = 1'b1; end
        end
        by_nxt = 9'(ny);
        if (dx) begin
          if ((bx + 11'sd8 <= 11'sd599) && (bx + 11'sd8 + sp >= 11'sd600) && ov1) begin
            bx_nxt = 10'd591; dx_nxt = 1'b0; hit = 1'b1;
          end else if (bx + sp > 11'sd631) begin
            miss = 1'b1; s0_nxt = score0 + 4'd1; dx_nxt = 1'b1;
          end else begin
            bx_nxt = 10'(bx + sp);
          end
        end else begin
          if ((bx >= 11'sd41) && (bx - sp <= 11'sd40) && ov0) begin
            bx_nxt = 10'd41; dx_nxt = 1'b1; hit = 1'b1;
          end else if (bx < sp) begin
            miss = 1'b1; s1_nxt = score1 + 4'd1; dx_nxt = 1'b0;
          end else begin
            bx_nxt = 10'(bx - sp);
          end
        end
        // A miss re-centres the ball and drops this frame's vertical update
        if (miss) begin
          bx_nxt  = CX;
          by_nxt  = CY;
          dy_nxt  = dy;
          cnt_nxt = '0;
          if (s0_nxt == WIN4)      begin state_nxt = S_OVER; win_nxt = 2'b01; end
          else if (s1_nxt == WIN4) begin state_nxt = S_OVER; win_nxt = 2'b10; end
          else                          state_nxt = S_POINT;
        end
      end
      S_POINT: if (tick) begin
        if (pause_cnt == PAUSE_LAST) begin
          state_nxt = S_PLAY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = pause_cnt + CW'(1);
        end
      end
      S_OVER: if (serve) begin
        state_nxt = S_IDLE;
        s0_nxt    = 4'd0;
        s1_nxt    = 4'd0;
        win_nxt   = 2'b00;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised self-checking bench for pong_game_ctrl against a frame-level game model.
module tb_pong_game_ctrl;
  localparam int BALL_SPEED = 2, WIN_SCORE = 9, PAUSE_FRAMES = 60, MAX_SPEED = 6;
  localparam int M_IDLE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;
  localparam int P_TRACK = 0, P_MISS = 1, P_RAND = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, VS = 1'b1, serve = 1'b0;
  logic [8:0] count_0 = '0, count_1 = '0;
  logic [5:0] paddlewidth = '0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score0, score1;
  logic [1:0] winner, state;
  logic [30:0] dut_vec;

  int n_checks = 0, n_fail = 0;
  int m_x, m_y, m_dx, m_dy, m_s0, m_s1, m_win, m_st, m_pause, m_spd;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALL_SPEED(BALL_SPEED), .WIN_SCORE(WIN_SCORE),
                   .PAUSE_FRAMES(PAUSE_FRAMES), .MAX_SPEED(MAX_SPEED)) dut (
    .clk(clk), .rst(rst), .VS(VS), .serve(serve),
    .count_0(count_0), .count_1(count_1), .paddlewidth(paddlewidth),
    .ball_x(ball_x), .ball_y(ball_y), .score0(score0), .score1(score1),
    .winner(winner), .state(state));

  assign dut_vec = {ball_x, ball_y, score0, score1, winner, state};

  function automatic void model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_s0 = 0; m_s1 = 0; m_win = 0; m_st = M_IDLE; m_pause = 0; m_spd = BALL_SPEED;
  endfunction

  function automatic logic [30:0] model_vec();
    return {10'(m_x), 9'(m_y), 4'(m_s0), 4'(m_s1), 2'(m_win), 2'(m_st)};
  endfunction

  // One video frame of game play, written directly from the game rules
  function automatic void model_tick(int c0, int c1, int pw);
    int nx, ny, ndx, ndy;
    bit hit, miss;
    if (m_st == M_POINT) begin
      m_pause++;
      if (m_pause == PAUSE_FRAMES) begin m_pause = 0; m_st = M_PLAY; end
      return;
    end
    if (m_st != M_PLAY) return;
    ny = m_y + m_dy * m_spd; ndy = m_dy;
    if (m_dy < 0 && ny < 11)  begin ny = 11;  ndy = 1;  end
    if (m_dy > 0 && ny > 461) begin ny = 461; ndy = -1; end
    nx = m_x + m_dx * m_spd; ndx = m_dx; hit = 0; miss = 0;
    if (m_dx < 0) begin
      if (m_x >= 41 && m_x - m_spd <= 40 && m_y + 8 >= c0 && m_y <= c0 + pw) begin
        nx = 41; ndx = 1; hit = 1;
      end else if (m_x < m_spd) begin
        miss = 1; m_s1++;
      end
    end else begin
      if (m_x + 8 <= 599 && m_x + 8 + m_spd >= 600 && m_y + 8 >= c1 && m_y <= c1 + pw) begin
        nx = 591; ndx = -1; hit = 1;
      end else if (m_x + m_spd > 631) begin
        miss = 1; m_s0++;
      end
    end
    if (miss) begin
      m_x = 316; m_y = 236; m_spd = BALL_SPEED; m_pause = 0;
      if (m_s0 == WIN_SCORE)      begin m_st = M_OVER; m_win = 1; end
      else if (m_s1 == WIN_SCORE) begin m_st = M_OVER; m_win = 2; end
      else m_st = M_POINT;
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
`ifdef SPEEDUP_EN
      if (hit && m_spd < MAX_SPEED) m_spd++;
`else
      if (hit) m_spd = BALL_SPEED;
`endif
    end
  endfunction

  task automatic set_paddles(input int mode);
    if (mode == P_TRACK) begin
      count_0 = 9'(m_y); count_1 = 9'(m_y); paddlewidth = 6'd40;
    end else if (mode == P_MISS) begin
      count_0 = '0; count_1 = '0; paddlewidth = '0;
    end else begin
      count_0 = 9'($urandom_range(0, 511)); count_1 = 9'($urandom_range(0, 511));
      paddlewidth = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic do_tick(input int mode);
    set_paddles(mode);
    @(negedge clk); VS = 1'b0;
    @(negedge clk); VS = 1'b1;
    model_tick(int'(count_0), int'(count_1), int'(paddlewidth));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic pulse_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
    if (m_st == M_IDLE) m_st = M_PLAY;
    else if (m_st == M_OVER) begin m_st = M_IDLE; m_s0 = 0; m_s1 = 0; m_win = 0; end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (dut_vec !== {10'd316, 9'd236, 4'd0, 4'd0, 2'b00, 2'b00}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_serve();
    do_tick(P_TRACK);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL idle_hold: got %h expected %h", dut_vec, model_vec());
    end
    pulse_serve();
    n_checks++;
    if (state !== 2'b01) begin
      n_fail++; $display("FAIL serve_to_play: got state %b expected 01", state);
    end
    do_tick(P_TRACK);
    n_checks++;
    if ({ball_x, ball_y} !== {10'd318, 9'd238}) begin
      n_fail++; $display("FAIL first_tick: got (%0d,%0d) expected (318,238)", ball_x, ball_y);
    end
    do_tick(P_TRACK);
    do_tick(P_TRACK);
    n_checks++;
    if ({ball_x, ball_y} !== {10'd322, 9'd242} || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL third_tick: got %h expected %h (x=322,y=242)", dut_vec, model_vec());
    end
  endtask

  task automatic test_paddle_hit();
    bit seen = 0;
    apply_reset();
    pulse_serve();
    for (int i = 0; i < 600 && !seen; i++) begin
      do_tick(P_TRACK);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL paddle_track tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (ball_x == 10'd41) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL left_hit_reached: got no x=41 within bound, expected x=41");
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(P_TRACK);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL after_left_hit %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_miss_pause();
    int n = 0;
    bit seen = 0;
    apply_reset();
    pulse_serve();
    for (int i = 0; i < 400 && !seen; i++) begin
      do_tick(P_MISS);
      if (state == 2'b10) seen = 1;
    end
    n_checks++;
    if (!seen || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL miss_point: got %h expected %h", dut_vec, model_vec());
    end
    while (state == 2'b10 && n < 200) begin
      do_tick(P_MISS);
      n++;
    end
    n_checks++;
    if (n !== PAUSE_FRAMES) begin
      n_fail++; $display("FAIL pause_length: got %0d ticks expected %0d", n, PAUSE_FRAMES);
    end
    do_tick(P_MISS);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL after_pause: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_gameover();
    bit seen = 0;
    apply_reset();
    pulse_serve();
    for (int i = 0; i < 5000 && !seen; i++) begin
      do_tick(P_MISS);
      if (dut_vec !== model_vec()) begin
        n_checks++; n_fail++;
        $display("FAIL gameover_run tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (state == 2'b11) seen = 1;
    end
    n_checks++;
    if (!seen || winner !== 2'b01 || score0 !== 4'd9 || score1 !== 4'd0) begin
      n_fail++; $display("FAIL gameover_reached: got s0=%0d s1=%0d win=%b st=%b expected 9 0 01 11",
                         score0, score1, winner, state);
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(P_RAND);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL gameover_frozen %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    pulse_serve();
    n_checks++;
    if (dut_vec !== {10'd316, 9'd236, 4'd0, 4'd0, 2'b00, 2'b00}) begin
      n_fail++; $display("FAIL gameover_serve: got %h expected %h", dut_vec, model_vec());
    end
    do_tick(P_TRACK);
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++; $display("FAIL idle_needs_serve: got state %b expected 00", state);
    end
  endtask

  task automatic test_reset_midplay();
    apply_reset();
    pulse_serve();
    for (int i = 0; i < 40; i++) do_tick(P_TRACK);
    apply_reset();
    n_checks++;
    if (dut_vec !== {10'd316, 9'd236, 4'd0, 4'd0, 2'b00, 2'b00}) begin
      n_fail++; $display("FAIL reset_midplay: got %h expected %h", dut_vec, model_vec());
    end
    pulse_serve();
    do_tick(P_TRACK);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_then_serve: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    pulse_serve();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_serve();
      do_tick(($urandom_range(0, 1) == 0) ? P_TRACK : P_RAND);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle_hit();
    test_miss_pause();
    test_gameover();
    test_reset_midplay();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
